// File: rtl/life_pkg.sv
// life_pkg: shared state encoding, widths and the per-cell B3/S23 rule
// used by the Game of Life stepper and its row rule.
package life_pkg;

    // Row address width of the arena port.
    localparam int ROW_ADDR_W = 10;

    // Width of the completed-generation counter.
    localparam int GEN_W = 16;

    // Stepper control states.
    typedef enum logic [2:0] {
        IDLE,
        FETCH_ADDR,
        FETCH_DATA,
        WRITE,
        PHANTOM
    } life_state_t;

    // A cell is born with exactly three neighbours and survives with two or three.
    function automatic logic life_next_cell(input logic alive, input logic [3:0] n);
        return (n == 4'd3) || (alive && (n == 4'd2));
    endfunction

endpackage

// File: rtl/life_row_rule.sv
// life_row_rule: purely combinational B3/S23 rule for one row, given the
// rows above and below it. With LIFE_TORUS_EN defined, column 0 and
// column ARENA_WIDTH-1 are neighbours. Otherwise the columns outside the
// arena read as dead.
module life_row_rule
    import life_pkg::*;
#(
    parameter int ARENA_WIDTH = 10
) (
    input  logic [ARENA_WIDTH-1:0] above,
    input  logic [ARENA_WIDTH-1:0] mid,
    input  logic [ARENA_WIDTH-1:0] below,
    output logic [ARENA_WIDTH-1:0] next_row
);

    // Each row gets one extra column on both sides. Bit c+1 holds column c.
    // Bit 0 is the column left of column 0, and bit ARENA_WIDTH+1 is the
    // column right of the last one.
    logic [ARENA_WIDTH+1:0] ext_above;
    logic [ARENA_WIDTH+1:0] ext_mid;
    logic [ARENA_WIDTH+1:0] ext_below;

`ifdef LIFE_TORUS_EN
    assign ext_above = {above[0], above, above[ARENA_WIDTH-1]};
    assign ext_mid   = {mid[0],   mid,   mid[ARENA_WIDTH-1]};
    assign ext_below = {below[0], below, below[ARENA_WIDTH-1]};
`else
    assign ext_above = {1'b0, above, 1'b0};
    assign ext_mid   = {1'b0, mid,   1'b0};
    assign ext_below = {1'b0, below, 1'b0};
`endif

    for (genvar c = 0; c < ARENA_WIDTH; c++) begin : g_cell
        logic [3:0] n;

        // Sum the eight neighbours around column c. The column itself in mid is excluded.
        assign n = 4'(ext_above[c]) + 4'(ext_above[c+1]) + 4'(ext_above[c+2])
                 + 4'(ext_mid[c])                         + 4'(ext_mid[c+2])
                 + 4'(ext_below[c]) + 4'(ext_below[c+1]) + 4'(ext_below[c+2]);

        assign next_row[c] = life_next_cell(ext_mid[c+1], n);
    end

endmodule

// File: rtl/life_stepper.sv
// life_stepper: computes one Game of Life generation in place over the
// arena row memory. It keeps a three-row sliding window, so that writing row r
// back never destroys data that rows r+1 and beyond still need.
// Optional feature: define LIFE_TORUS_EN for a toroidal arena. The default
// build is a flat arena, where cells outside the arena are dead.
module life_stepper
    import life_pkg::*;
#(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   ready,
    output logic [GEN_W-1:0]       generation,
    output logic [ROW_ADDR_W-1:0]  arena_row_select,
    input  logic [ARENA_WIDTH-1:0] arena_columns_current,
    output logic [ARENA_WIDTH-1:0] arena_columns_new,
    output logic                   arena_columns_write
);

    localparam logic [ROW_ADDR_W-1:0] LAST_ROW = ROW_ADDR_W'(ARENA_HEIGHT - 1);
    // The row after row r can still be fetched from the arena only while r < H-2.
    localparam logic [ROW_ADDR_W-1:0] PEN_ROW  = ROW_ADDR_W'(ARENA_HEIGHT - 2);

`ifdef LIFE_TORUS_EN
    // Priming fetches H-1, 0, 1, so that row 0 sees its wrapped upper neighbour.
    localparam logic [1:0]            PRIME_LAST  = 2'd2;
    localparam logic [ROW_ADDR_W-1:0] FIRST_FETCH = LAST_ROW;
`else
    // Priming fetches 0, 1. The cleared window supplies the dead row above row 0.
    localparam logic [1:0]            PRIME_LAST  = 2'd1;
    localparam logic [ROW_ADDR_W-1:0] FIRST_FETCH = '0;
`endif

    life_state_t              state;
    logic [ARENA_WIDTH-1:0]   above;
    logic [ARENA_WIDTH-1:0]   mid;
    logic [ARENA_WIDTH-1:0]   below;
    logic [ROW_ADDR_W-1:0]    write_row;
    logic [ROW_ADDR_W-1:0]    fetch_row;
    logic [ROW_ADDR_W-1:0]    next_fetch;
    logic [1:0]               prime_cnt;
    logic [ARENA_WIDTH-1:0]   phantom_row;
    logic [ARENA_WIDTH-1:0]   shift_in;
    logic [ARENA_WIDTH-1:0]   rule_row;

`ifdef LIFE_TORUS_EN
    // The original row 0 is kept, because row 0 has already been overwritten when the last row needs it.
    logic [ARENA_WIDTH-1:0]   row0_orig;
    assign phantom_row = row0_orig;
`else
    assign phantom_row = '0;
`endif

    // The fetch pointer steps through rows and wraps from the last row back to row 0.
    assign next_fetch = (fetch_row == LAST_ROW) ? '0 : fetch_row + ROW_ADDR_W'(1);

    // The row entering the window is the arena read data, or the virtual row below the arena in PHANTOM.
    assign shift_in = (state == PHANTOM) ? phantom_row : arena_columns_current;

    // The rule is evaluated on the window as it will be after this cycle's shift.
    // The result is then registered at the same edge as the shift.
    life_row_rule #(
        .ARENA_WIDTH(ARENA_WIDTH)
    ) u_row_rule (
        .above   (mid),
        .mid     (below),
        .below   (shift_in),
        .next_row(rule_row)
    );

    // Control FSM, sliding window and all registered arena-port outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            ready               <= 1'b1;
            generation          <= '0;
            arena_row_select    <= '0;
            arena_columns_new   <= '0;
            arena_columns_write <= 1'b0;
            above               <= '0;
            mid                 <= '0;
            below               <= '0;
`ifdef LIFE_TORUS_EN
            row0_orig           <= '0;
`endif
            write_row           <= '0;
            fetch_row           <= '0;
            prime_cnt           <= '0;
        end else begin
            arena_columns_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        above            <= '0;
                        mid              <= '0;
                        below            <= '0;
                        write_row        <= '0;
                        prime_cnt        <= '0;
                        fetch_row        <= FIRST_FETCH;
                        arena_row_select <= FIRST_FETCH;
                        ready            <= 1'b0;
                        state            <= FETCH_ADDR;
                    end
                end

                FETCH_ADDR: begin
                    state <= FETCH_DATA;
                end

                FETCH_DATA: begin
                    above     <= mid;
                    mid       <= below;
                    below     <= arena_columns_current;
`ifdef LIFE_TORUS_EN
                    if (fetch_row == '0) begin
                        row0_orig <= arena_columns_current;
                    end
`endif
                    fetch_row <= next_fetch;
                    if (prime_cnt < PRIME_LAST) begin
                        prime_cnt        <= prime_cnt + 2'd1;
                        arena_row_select <= next_fetch;
                        state            <= FETCH_ADDR;
                    end else begin
                        arena_columns_new   <= rule_row;
                        arena_row_select    <= write_row;
                        arena_columns_write <= 1'b1;
                        state               <= WRITE;
                    end
                end

                WRITE: begin
                    if (write_row == LAST_ROW) begin
                        generation <= generation + GEN_W'(1);
                        ready      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        write_row <= write_row + ROW_ADDR_W'(1);
                        if (write_row < PEN_ROW) begin
                            arena_row_select <= fetch_row;
                            state            <= FETCH_ADDR;
                        end else begin
                            state <= PHANTOM;
                        end
                    end
                end

                PHANTOM: begin
                    above               <= mid;
                    mid                 <= below;
                    below               <= phantom_row;
                    arena_columns_new   <= rule_row;
                    arena_row_select    <= write_row;
                    arena_columns_write <= 1'b1;
                    state               <= WRITE;
                end

                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
